// File: rtl/pll_pkg.sv
// Shared encodings and defaults for the PLL lock detector.
// Imported by the lock detector interface and top level.
package pll_pkg;

    localparam int DEF_CNT_W        = 16;
    localparam int DEF_PHASE_TOL    = 4;
    localparam int DEF_LOCK_COUNT   = 16;
    localparam int DEF_UNLOCK_COUNT = 4;

    // phase_err is positive when the feedback edge arrives before the VCO edge
    localparam logic FB_LEAD_POSITIVE = 1'b1;

    typedef enum logic [1:0] {
        PH_IDLE     = 2'd0,
        PH_WAIT_VCO = 2'd1,
        PH_WAIT_FB  = 2'd2
    } phase_state_e;

    typedef enum logic {
        LK_UNLOCKED = 1'b0,
        LK_LOCKED   = 1'b1
    } lock_state_e;

endpackage

// File: rtl/pll_lock_detect_if.sv
// Bundle of the lock detector's clock-domain inputs and measurement outputs.
// The master side drives fb_u/vco; the slave side (the detector) drives results.
interface pll_lock_detect_if
    import pll_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             fb_u;
    logic             vco;
    logic             lock;
    logic [CNT_W-1:0] phase_err;
    logic             meas_valid;
    logic [CNT_W-1:0] fb_period;
    logic             timeout;

    modport master (
        output fb_u,
        output vco,
        input  lock,
        input  phase_err,
        input  meas_valid,
        input  fb_period,
        input  timeout
    );

    modport slave (
        input  fb_u,
        input  vco,
        output lock,
        output phase_err,
        output meas_valid,
        output fb_period,
        output timeout
    );
endinterface

// File: rtl/edge_sync.sv
// Optional N-stage synchronizer followed by a registered rising-edge detector.
// With STAGES=0 the input is assumed already synchronous and only the edge flop is used.
module edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);
    logic level_s;
    logic prev_q;

    generate
        if (STAGES > 0) begin : g_sync
            logic [STAGES-1:0] sync_q;

            // metastability chain; sync_q[STAGES-1] is the clean level
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= d_i;
                    for (int i = 1; i < STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign level_s = sync_q[STAGES-1];
        end else begin : g_pass
            assign level_s = d_i;
        end
    endgenerate

    // previous level for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level_s;
        end
    end

    assign rise_o = level_s & ~prev_q;

endmodule

// File: rtl/pll_lock_detect.sv
// PLL lock detector: signed fb-vs-vco phase error, fb period, and a hysteretic lock flag.
// All results are registered; a measurement closes one edge after the closing rising edge.
module pll_lock_detect
    import pll_pkg::*;
#(
    parameter int               CNT_W        = DEF_CNT_W,
    parameter int               PHASE_TOL    = DEF_PHASE_TOL,
    parameter int               LOCK_COUNT   = DEF_LOCK_COUNT,
    parameter int               UNLOCK_COUNT = DEF_UNLOCK_COUNT,
    parameter logic [CNT_W-1:0] TIMEOUT      = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    pll_lock_detect_if.slave bus
);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] PCNT_ABORT = TIMEOUT - ONE;
    localparam logic [CNT_W-1:0] TOL_W      = CNT_W'(PHASE_TOL);
    localparam logic [CNT_W-1:0] LOCK_W     = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] UNLOCK_W   = CNT_W'(UNLOCK_COUNT);

    logic fb_rise_s;
    logic vco_rise_s;

    edge_sync #(.STAGES(2)) u_fb_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (bus.fb_u),
        .rise_o (fb_rise_s)
    );

    edge_sync #(.STAGES(0)) u_vco_edge (
        .clk    (clk),
        .rst    (rst),
        .d_i    (bus.vco),
        .rise_o (vco_rise_s)
    );

    phase_state_e     ph_q, ph_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] pcnt_inc_s;
    logic             done_s;
    logic             abort_s;
    logic             fb_leads_s;
    logic [CNT_W-1:0] mag_s;
    logic [CNT_W-1:0] err_s;
    logic             good_s;
    logic             bad_s;

    assign pcnt_inc_s = pcnt_q + ONE;

    // phase FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q   <= PH_IDLE;
            pcnt_q <= '0;
        end else begin
            ph_q   <= ph_d;
            pcnt_q <= pcnt_d;
        end
    end

    // phase FSM: the closing edge has priority over a restart by the opening edge
    always_comb begin
        ph_d       = ph_q;
        pcnt_d     = pcnt_q;
        done_s     = 1'b0;
        abort_s    = 1'b0;
        fb_leads_s = 1'b0;
        mag_s      = '0;
        case (ph_q)
            PH_IDLE: begin
                if (fb_rise_s && vco_rise_s) begin
                    done_s = 1'b1;
                end else if (fb_rise_s) begin
                    ph_d   = PH_WAIT_VCO;
                    pcnt_d = '0;
                end else if (vco_rise_s) begin
                    ph_d   = PH_WAIT_FB;
                    pcnt_d = '0;
                end else begin
                    ph_d = PH_IDLE;
                end
            end
            PH_WAIT_VCO: begin
                if (vco_rise_s) begin
                    done_s     = 1'b1;
                    fb_leads_s = 1'b1;
                    mag_s      = pcnt_inc_s;
                    ph_d       = PH_IDLE;
                    pcnt_d     = '0;
                end else if (fb_rise_s) begin
                    pcnt_d = '0;
                end else if (pcnt_inc_s == PCNT_ABORT) begin
                    abort_s = 1'b1;
                    ph_d    = PH_IDLE;
                    pcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_inc_s;
                end
            end
            PH_WAIT_FB: begin
                if (fb_rise_s) begin
                    done_s     = 1'b1;
                    fb_leads_s = 1'b0;
                    mag_s      = pcnt_inc_s;
                    ph_d       = PH_IDLE;
                    pcnt_d     = '0;
                end else if (vco_rise_s) begin
                    pcnt_d = '0;
                end else if (pcnt_inc_s == PCNT_ABORT) begin
                    abort_s = 1'b1;
                    ph_d    = PH_IDLE;
                    pcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_inc_s;
                end
            end
            default: begin
                ph_d   = PH_IDLE;
                pcnt_d = '0;
            end
        endcase
    end

    // magnitude is judged unsigned so the tolerance test never depends on the sign encoding
    assign err_s  = (fb_leads_s == FB_LEAD_POSITIVE) ? mag_s : (~mag_s + ONE);
    assign good_s = done_s && (mag_s <= TOL_W);
    assign bad_s  = abort_s || (done_s && (mag_s > TOL_W));

    logic [CNT_W-1:0] phase_err_q;
    logic             meas_valid_q;
    logic             timeout_q;

    // registered measurement results and sticky timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_err_q  <= '0;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            meas_valid_q <= done_s;
            if (done_s) begin
                phase_err_q <= err_s;
            end
            if (abort_s) begin
                timeout_q <= 1'b1;
            end
        end
    end

    lock_state_e      lk_q, lk_d;
    logic [CNT_W-1:0] gcnt_q, gcnt_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;

    // lock FSM state and run-length counters
    always_ff @(posedge clk) begin
        if (rst) begin
            lk_q   <= LK_UNLOCKED;
            gcnt_q <= '0;
            bcnt_q <= '0;
        end else begin
            lk_q   <= lk_d;
            gcnt_q <= gcnt_d;
            bcnt_q <= bcnt_d;
        end
    end

    // lock hysteresis: consecutive good results to lock, consecutive bad results to unlock
    always_comb begin
        lk_d   = lk_q;
        gcnt_d = gcnt_q;
        bcnt_d = bcnt_q;
        case (lk_q)
            LK_UNLOCKED: begin
                bcnt_d = '0;
                if (good_s) begin
                    if ((gcnt_q + ONE) == LOCK_W) begin
                        lk_d   = LK_LOCKED;
                        gcnt_d = '0;
                    end else begin
                        gcnt_d = gcnt_q + ONE;
                    end
                end else if (bad_s) begin
                    gcnt_d = '0;
                end else begin
                    gcnt_d = gcnt_q;
                end
            end
            LK_LOCKED: begin
                gcnt_d = '0;
                if (bad_s) begin
                    if ((bcnt_q + ONE) == UNLOCK_W) begin
                        lk_d   = LK_UNLOCKED;
                        bcnt_d = '0;
                    end else begin
                        bcnt_d = bcnt_q + ONE;
                    end
                end else if (good_s) begin
                    bcnt_d = '0;
                end else begin
                    bcnt_d = bcnt_q;
                end
            end
            default: begin
                lk_d   = LK_UNLOCKED;
                gcnt_d = '0;
                bcnt_d = '0;
            end
        endcase
    end

    logic [CNT_W-1:0] fcnt_q;
    logic [CNT_W-1:0] fcnt_inc_s;
    logic [CNT_W-1:0] fb_period_q;
    logic             fb_seen_q;

    assign fcnt_inc_s = (fcnt_q == {CNT_W{1'b1}}) ? fcnt_q : (fcnt_q + ONE);

    // fb period counter; the first edge after reset only arms the measurement
    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_q      <= '0;
            fb_period_q <= '0;
            fb_seen_q   <= 1'b0;
        end else if (fb_rise_s) begin
            fcnt_q    <= '0;
            fb_seen_q <= 1'b1;
            if (fb_seen_q) begin
                fb_period_q <= fcnt_inc_s;
            end
        end else begin
            fcnt_q <= fcnt_inc_s;
        end
    end

    assign bus.lock       = (lk_q == LK_LOCKED);
    assign bus.phase_err  = phase_err_q;
    assign bus.meas_valid = meas_valid_q;
    assign bus.fb_period  = fb_period_q;
    assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_pll_lock_detect.sv
// Directed bench for pll_lock_detect: edge pairs with hand-computed phase/period/lock results.
// err = vco_rise_cycle - (fb_u_raise_cycle + 2) because fb_u crosses a 2-flop synchronizer.
module tb_pll_lock_detect;

    logic clk = 1'b0;
    logic rst;

    always #10 clk = ~clk;

    pll_lock_detect_if #(.CNT_W(16)) bus_if ();

    pll_lock_detect #(
        .CNT_W        (16),
        .PHASE_TOL    (4),
        .LOCK_COUNT   (16),
        .UNLOCK_COUNT (4),
        .TIMEOUT      (16'hFFFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          mv_cnt   = 0;
    logic [15:0] last_err = 16'h0000;
    logic        last_lock = 1'b0;

    // capture every measurement pulse away from the active edge
    always @(negedge clk) begin
        if (bus_if.meas_valid) begin
            mv_cnt    <= mv_cnt + 1;
            last_err  <= bus_if.phase_err;
            last_lock <= bus_if.lock;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one 200-cycle window holding a single fb/vco rising-edge pair with the given error
    task automatic run_pair(input int err);
        int tf;
        int tv;
        if (err >= 0) begin
            tf = 0;
            tv = err + 2;
        end else begin
            tv = 0;
            tf = -err - 2;
        end
        for (int c = 0; c < 200; c++) begin
            if (c == tf)       bus_if.fb_u = 1'b1;
            if (c == tv)       bus_if.vco  = 1'b1;
            if (c == tf + 100) bus_if.fb_u = 1'b0;
            if (c == tv + 100) bus_if.vco  = 1'b0;
            tick();
        end
    endtask

    initial begin
        int mv0;
        int n;

        rst         = 1'b1;
        bus_if.fb_u = 1'b0;
        bus_if.vco  = 1'b0;
        tick();
        tick();
        check_eq("rst_lock",       32'(bus_if.lock),       32'd0);
        check_eq("rst_phase_err",  32'(bus_if.phase_err),  32'd0);
        check_eq("rst_meas_valid", 32'(bus_if.meas_valid), 32'd0);
        check_eq("rst_fb_period",  32'(bus_if.fb_period),  32'd0);
        check_eq("rst_timeout",    32'(bus_if.timeout),    32'd0);
        rst = 1'b0;
        tick();

        // fb leads by 3: good, first fb edge does not latch a period
        run_pair(3);
        check_eq("lead3_cnt",    32'(mv_cnt),            32'd1);
        check_eq("lead3_err",    32'(last_err),          32'd3);
        check_eq("lead3_out",    32'(bus_if.phase_err),  32'd3);
        check_eq("lead3_mv_low", 32'(bus_if.meas_valid), 32'd0);
        check_eq("lead3_lock",   32'(bus_if.lock),       32'd0);
        check_eq("lead3_period", 32'(bus_if.fb_period),  32'd0);

        // vco leads by 7: bad; fb edge moved 5 cycles later than the previous window
        run_pair(-7);
        check_eq("lag7_cnt",    32'(mv_cnt),           32'd2);
        check_eq("lag7_err",    32'(last_err),         32'h0000FFF9);
        check_eq("lag7_period", 32'(bus_if.fb_period), 32'd205);

        // 16 aligned pairs: lock rises together with the 16th pulse
        for (int i = 0; i < 15; i++) run_pair(0);
        check_eq("align15_lock",   32'(last_lock),        32'd0);
        check_eq("align15_cnt",    32'(mv_cnt),           32'd17);
        run_pair(0);
        check_eq("align16_lock",   32'(last_lock),        32'd1);
        check_eq("align16_err",    32'(last_err),         32'd0);
        check_eq("align16_period", 32'(bus_if.fb_period), 32'd200);

        // 3 bad then 1 good keep lock; 4 bad in a row drop it on the 4th
        for (int i = 0; i < 3; i++) run_pair(10);
        check_eq("bad3_err",  32'(last_err),  32'd10);
        run_pair(2);
        check_eq("good_err",  32'(last_err),  32'd2);
        check_eq("good_lock", 32'(last_lock), 32'd1);
        for (int i = 0; i < 3; i++) run_pair(10);
        check_eq("bad3b_lock", 32'(last_lock), 32'd1);
        run_pair(10);
        check_eq("bad4_lock", 32'(last_lock),   32'd0);
        check_eq("bad4_out",  32'(bus_if.lock), 32'd0);
        check_eq("bad4_cnt",  32'(mv_cnt),      32'd26);

        // fb rises, vco never does: abort after the counter runs out
        mv0 = mv_cnt;
        bus_if.fb_u = 1'b1;
        n = 0;
        while (!bus_if.timeout && n < 70000) begin
            tick();
            n++;
        end
        check_eq("to_flag",   32'(bus_if.timeout), 32'd1);
        check_eq("to_cycles", 32'(n),              32'd65537);
        check_eq("to_no_mv",  32'(mv_cnt),         32'(mv0));
        check_eq("to_lock",   32'(bus_if.lock),    32'd0);
        bus_if.fb_u = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // FSM is back in IDLE: aligned pairs measure normally and relock
        run_pair(0);
        check_eq("post_to_cnt",  32'(mv_cnt),         32'(mv0 + 1));
        check_eq("post_to_err",  32'(last_err),       32'd0);
        check_eq("post_to_stky", 32'(bus_if.timeout), 32'd1);
        for (int i = 0; i < 15; i++) run_pair(0);
        check_eq("relock", 32'(bus_if.lock), 32'd1);

        // reset in WAIT_VCO while locked discards everything
        bus_if.fb_u = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rst         = 1'b1;
        bus_if.fb_u = 1'b0;
        tick();
        check_eq("mid_rst_lock",   32'(bus_if.lock),       32'd0);
        check_eq("mid_rst_err",    32'(bus_if.phase_err),  32'd0);
        check_eq("mid_rst_mv",     32'(bus_if.meas_valid), 32'd0);
        check_eq("mid_rst_period", 32'(bus_if.fb_period),  32'd0);
        check_eq("mid_rst_to",     32'(bus_if.timeout),    32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        mv0 = mv_cnt;
        run_pair(2);
        check_eq("after_rst_cnt",    32'(mv_cnt),           32'(mv0 + 1));
        check_eq("after_rst_err",    32'(last_err),         32'd2);
        check_eq("after_rst_period", 32'(bus_if.fb_period), 32'd0);
        run_pair(-4);
        check_eq("after_rst_neg",     32'(last_err),         32'h0000FFFC);
        check_eq("after_rst_period2", 32'(bus_if.fb_period), 32'd202);
        check_eq("after_rst_lock",    32'(bus_if.lock),      32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
